// File: rtl/tlc_conflict_monitor_pkg.sv
// Shared definitions for the traffic light safety monitor and its controller.
// Holds the lamp colour codes, fault codes, monitor state encoding and two
// small colour helpers.
package tlc_conflict_monitor_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_ENC      = 3'd1,
    FC_CONFLICT = 3'd2,
    FC_SEQ      = 3'd3,
    FC_MIN      = 3'd4,
    FC_STUCK    = 3'd5
  } fault_code_e;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  function automatic logic is_colour(input logic [2:0] c);
    return (c == RED) || (c == YELLOW) || (c == GREEN);
  endfunction

  // Only green->yellow, yellow->red and red->green are legal changes.
  function automatic logic legal_step(input logic [2:0] from, input logic [2:0] to);
    return ((from == GREEN)  && (to == YELLOW)) ||
           ((from == YELLOW) && (to == RED))    ||
           ((from == RED)    && (to == GREEN));
  endfunction

endpackage

// File: rtl/tlc_dir_tracker.sv
// Per-direction history tracker for the conflict monitor.
// Tracks the previous colour, how long it has been held, and whether the
// current interval is the first one seen since monitoring started.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr         forget all history (used whenever the top is not monitoring)
//   en          sample y this cycle
//   y           one-hot colour from the controller
//   enc_err     y is not a valid colour
//   seq_err     illegal colour change
//   min_err     left green/yellow too early (not in the first interval)
//   stuck_err   colour held for MAX_HOLD cycles
module tlc_dir_tracker
  import tlc_conflict_monitor_pkg::*;
#(
  parameter int CNT_W      = 7,
  parameter int MIN_GREEN  = 8,
  parameter int MIN_YELLOW = 3,
  parameter int MAX_HOLD   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [2:0] y,
  output logic       enc_err,
  output logic       seq_err,
  output logic       min_err,
  output logic       stuck_err
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] G_MIN    = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] Y_MIN    = CNT_W'(MIN_YELLOW);

  logic [2:0]       prev_q, prev_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             armed_q, armed_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] hold_inc;

  assign hold_inc = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + CNT_W'(1);

  always_comb begin
    prev_d    = prev_q;
    hold_d    = hold_q;
    armed_d   = armed_q;
    first_d   = first_q;
    enc_err   = 1'b0;
    seq_err   = 1'b0;
    min_err   = 1'b0;
    stuck_err = 1'b0;
    if (clr) begin
      prev_d  = DARK;
      hold_d  = '0;
      armed_d = 1'b0;
      first_d = 1'b0;
    end else if (en) begin
      enc_err = !is_colour(y);
      if (!armed_q) begin
        // First sample only captures the colour.
        prev_d  = y;
        hold_d  = CNT_W'(1);
        armed_d = 1'b1;
        first_d = 1'b1;
      end else if (y == prev_q) begin
        hold_d    = hold_inc;
        stuck_err = (hold_inc == HOLD_MAX);
      end else begin
        seq_err = !legal_step(prev_q, y);
        // The interval already running when monitoring began has unknown length.
        min_err = !first_q &&
                  (((prev_q == GREEN)  && (hold_q < G_MIN)) ||
                   ((prev_q == YELLOW) && (hold_q < Y_MIN)));
        prev_d  = y;
        hold_d  = CNT_W'(1);
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= DARK;
      hold_q  <= '0;
      armed_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      hold_q  <= hold_d;
      armed_q <= armed_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamps.
// Passes the controller colours to the lamps with one cycle of latency while
// checking encoding, conflicts, sequence, minimum times and stuck lamps. Any
// violation latches a fault and flashes red in both directions until cleared.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   yNS, yEW            controller colours (100 red, 010 yellow, 001 green)
//   clr_fault           pulse that releases a latched fault
//   lampNS, lampEW      registered lamp drive, 000 = dark
//   fault               latched fault flag
//   fault_code          0 none, 1 enc, 2 conflict, 3 seq, 4 min-time, 5 stuck
//   fault_dir           0 NS, 1 EW (0 for conflict)
//   fault_cnt           saturating number of fault entries
module tlc_conflict_monitor
  import tlc_conflict_monitor_pkg::*;
#(
  parameter int STARTUP_CYC = 8,
  parameter int MIN_GREEN   = 8,
  parameter int MIN_YELLOW  = 3,
  parameter int MAX_HOLD    = 64,
  parameter int FLASH_HALF  = 4,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] yNS,
  input  logic [2:0] yEW,
  input  logic       clr_fault,
  output logic [2:0] lampNS,
  output logic [2:0] lampEW,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       fault_dir,
  output logic [7:0] fault_cnt
);

  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST   = CNT_W'(FLASH_HALF - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;        // startup length or flash phase length
  logic             flash_on_q, flash_on_d;
  logic [2:0]       lamp_ns_q, lamp_ns_d, lamp_ew_q, lamp_ew_d;
  logic             fault_q, fault_d, dir_q, dir_d;
  fault_code_e      code_q, code_d;
  logic [7:0]       fcnt_q, fcnt_d;

  logic        mon;
  logic        ns_enc, ns_seq, ns_min, ns_stuck;
  logic        ew_enc, ew_seq, ew_min, ew_stuck;
  logic        conflict;
  fault_code_e det_code;
  logic        det_dir;

  assign mon = (state_q == ST_MONITOR);

  tlc_dir_tracker #(
    .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .MAX_HOLD(MAX_HOLD)
  ) u_trk_ns (
    .clk(clk), .rst(rst), .clr(!mon), .en(mon), .y(yNS),
    .enc_err(ns_enc), .seq_err(ns_seq), .min_err(ns_min), .stuck_err(ns_stuck)
  );

  tlc_dir_tracker #(
    .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .MAX_HOLD(MAX_HOLD)
  ) u_trk_ew (
    .clk(clk), .rst(rst), .clr(!mon), .en(mon), .y(yEW),
    .enc_err(ew_enc), .seq_err(ew_seq), .min_err(ew_min), .stuck_err(ew_stuck)
  );

  assign conflict = mon && (yNS != RED) && (yEW != RED);

  // Lowest code wins; within a code NS is reported before EW.
  always_comb begin
    det_code = FC_NONE;
    det_dir  = 1'b0;
    if      (ns_enc)   det_code = FC_ENC;
    else if (ew_enc)   begin det_code = FC_ENC;   det_dir = 1'b1; end
    else if (conflict) det_code = FC_CONFLICT;
    else if (ns_seq)   det_code = FC_SEQ;
    else if (ew_seq)   begin det_code = FC_SEQ;   det_dir = 1'b1; end
    else if (ns_min)   det_code = FC_MIN;
    else if (ew_min)   begin det_code = FC_MIN;   det_dir = 1'b1; end
    else if (ns_stuck) det_code = FC_STUCK;
    else if (ew_stuck) begin det_code = FC_STUCK; det_dir = 1'b1; end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flash_on_d = flash_on_q;
    case (state_q)
      ST_STARTUP: begin
        if (cnt_q == STARTUP_LAST) begin
          state_d = ST_MONITOR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MONITOR: begin
        if (det_code != FC_NONE) begin
          state_d    = ST_FAULT;
          cnt_d      = '0;
          flash_on_d = 1'b1;
        end
      end
      ST_FAULT: begin
        if (clr_fault) begin
          state_d    = ST_STARTUP;
          cnt_d      = '0;
          flash_on_d = 1'b1;
        end else if (cnt_q == FLASH_LAST) begin
          cnt_d      = '0;
          flash_on_d = !flash_on_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STARTUP;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: lamp drive and fault reporting.
  always_comb begin
    lamp_ns_d = lamp_ns_q;
    lamp_ew_d = lamp_ew_q;
    fault_d   = fault_q;
    code_d    = code_q;
    dir_d     = dir_q;
    fcnt_d    = fcnt_q;
    case (state_q)
      ST_MONITOR: begin
        if (det_code != FC_NONE) begin
          // Offending inputs are replaced by red on the same edge.
          lamp_ns_d = RED;
          lamp_ew_d = RED;
          fault_d   = 1'b1;
          code_d    = det_code;
          dir_d     = det_dir;
          fcnt_d    = (fcnt_q == 8'hFF) ? fcnt_q : fcnt_q + 8'd1;
        end else begin
          lamp_ns_d = yNS;
          lamp_ew_d = yEW;
        end
      end
      ST_FAULT: begin
        if (clr_fault) begin
          lamp_ns_d = RED;
          lamp_ew_d = RED;
          fault_d   = 1'b0;
          code_d    = FC_NONE;
          dir_d     = 1'b0;
        end else begin
          lamp_ns_d = flash_on_d ? RED : DARK;
          lamp_ew_d = flash_on_d ? RED : DARK;
        end
      end
      default: begin
        lamp_ns_d = RED;
        lamp_ew_d = RED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STARTUP;
      cnt_q      <= '0;
      flash_on_q <= 1'b1;
      lamp_ns_q  <= RED;
      lamp_ew_q  <= RED;
      fault_q    <= 1'b0;
      code_q     <= FC_NONE;
      dir_q      <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flash_on_q <= flash_on_d;
      lamp_ns_q  <= lamp_ns_d;
      lamp_ew_q  <= lamp_ew_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
      dir_q      <= dir_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign lampNS     = lamp_ns_q;
  assign lampEW     = lamp_ew_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_dir  = dir_q;
  assign fault_cnt  = fcnt_q;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Bench for tlc_conflict_monitor: hand-written vector table, directed corner
// sequences and randomized traffic checked against a cycle-level model.
module tb_tlc_conflict_monitor;

  localparam int STARTUP_CYC = 8;
  localparam int MIN_GREEN   = 8;
  localparam int MIN_YELLOW  = 3;
  localparam int MAX_HOLD    = 64;
  localparam int FLASH_HALF  = 4;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, D = 3'b000;

  logic       clk, rst, clr_fault;
  logic [2:0] yNS, yEW, lampNS, lampEW, fault_code;
  logic       fault, fault_dir;
  logic [7:0] fault_cnt;

  int checks = 0;
  int errors = 0;

  tlc_conflict_monitor #(
    .STARTUP_CYC(STARTUP_CYC), .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW),
    .MAX_HOLD(MAX_HOLD), .FLASH_HALF(FLASH_HALF), .CNT_W(7)
  ) dut (
    .clk(clk), .rst(rst), .yNS(yNS), .yEW(yEW), .clr_fault(clr_fault),
    .lampNS(lampNS), .lampEW(lampEW), .fault(fault), .fault_code(fault_code),
    .fault_dir(fault_dir), .fault_cnt(fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // mode 0 = all-red startup, 1 = monitoring, 2 = flashing fault.
  int         m_mode = 0, m_t = 0;
  int         m_last[2];     // colour index (R=0,G=1,Y=2), -1 = nothing seen
  int         m_run[2];      // cycles the current colour has been seen
  bit         m_first[2];
  bit         m_fault = 0;
  int         m_code = 0, m_dir = 0, m_cnt = 0;
  logic [2:0] m_lns = R, m_lew = R;

  function automatic int cidx(input logic [2:0] c);
    if (c == R) return 0;
    if (c == G) return 1;
    if (c == Y) return 2;
    return -1;
  endfunction

  function automatic int min_hold(input int i);
    if (i == 1) return MIN_GREEN;
    if (i == 2) return MIN_YELLOW;
    return 0;
  endfunction

  task automatic model_step(input bit r, input logic [2:0] yn, input logic [2:0] ye, input bit c);
    logic [2:0] yy[2];
    int best, i;
    yy[0] = yn; yy[1] = ye;
    if (r) begin
      m_mode = 0; m_t = 0; m_fault = 0; m_code = 0; m_dir = 0; m_cnt = 0;
      m_lns = R; m_lew = R;
      return;
    end
    if (m_mode == 0) begin
      m_t++;
      m_lns = R; m_lew = R;
      if (m_t == STARTUP_CYC) begin
        m_mode = 1;
        m_last[0] = -1; m_last[1] = -1;
      end
    end else if (m_mode == 1) begin
      // Each violation scores code*2+dir; the smallest score is reported.
      best = 99;
      if (yn != R && ye != R) best = 4;
      for (int d = 0; d < 2; d++) begin
        i = cidx(yy[d]);
        if ($countones(yy[d]) != 1 && 2 + d < best) best = 2 + d;
        if (m_last[d] >= 0) begin
          if (i == m_last[d]) begin
            if (m_run[d] + 1 >= MAX_HOLD && 10 + d < best) best = 10 + d;
          end else begin
            if (i != (m_last[d] + 1) % 3 && 6 + d < best) best = 6 + d;
            if (!m_first[d] && m_run[d] < min_hold(m_last[d]) && 8 + d < best) best = 8 + d;
          end
        end
      end
      if (best != 99) begin
        m_mode = 2; m_t = 0; m_fault = 1;
        m_code = best / 2; m_dir = best % 2;
        if (m_cnt < 255) m_cnt++;
        m_lns = R; m_lew = R;
      end else begin
        m_lns = yn; m_lew = ye;
        for (int d = 0; d < 2; d++) begin
          i = cidx(yy[d]);
          if (m_last[d] < 0) begin
            m_last[d] = i; m_run[d] = 1; m_first[d] = 1;
          end else if (i == m_last[d]) begin
            m_run[d]++;
          end else begin
            m_last[d] = i; m_run[d] = 1; m_first[d] = 0;
          end
        end
      end
    end else begin
      if (c) begin
        m_mode = 0; m_t = 0; m_fault = 0; m_code = 0; m_dir = 0;
        m_lns = R; m_lew = R;
      end else begin
        m_t++;
        m_lns = ((m_t / FLASH_HALF) % 2 == 0) ? R : D;
        m_lew = m_lns;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare every output.
  task automatic tick(input logic [2:0] yn, input logic [2:0] ye, input bit c, input bit r);
    yNS = yn; yEW = ye; clr_fault = c; rst = r;
    @(posedge clk);
    model_step(r, yn, ye, c);
    #1;
    chk("model lampNS", int'(lampNS), int'(m_lns));
    chk("model lampEW", int'(lampEW), int'(m_lew));
    chk("model fault", int'(fault), int'(m_fault));
    chk("model fault_code", int'(fault_code), m_code);
    chk("model fault_dir", int'(fault_dir), m_dir);
    chk("model fault_cnt", int'(fault_cnt), m_cnt);
  endtask

  task automatic reset_and_start();
    tick(D, D, 0, 1);
    chk("reset lampNS", int'(lampNS), int'(R));
    chk("reset fault_cnt", int'(fault_cnt), 0);
    for (int k = 0; k < STARTUP_CYC; k++) begin
      tick(D, D, 0, 0);
      chk("startup no fault", int'(fault), 0);
    end
  endtask

  typedef struct {
    logic [2:0] yn, ye;
    bit         clr;
    logic [2:0] lns, lew;
    bit         flt;
    int         code;
    int         cnt;
  } vec_t;

  typedef struct {
    logic [2:0] yn, ye;
    int         len;
  } phase_t;

  vec_t   tbl[12];
  phase_t ph[6];
  logic [2:0] rn, re;
  int r;

  initial begin
    // Conflict during monitoring, then the flash pattern, then clear.
    tbl[0]  = '{G, R, 0, G, R, 0, 0, 0};
    tbl[1]  = '{G, R, 0, G, R, 0, 0, 0};
    tbl[2]  = '{G, G, 0, R, R, 1, 2, 1};
    tbl[3]  = '{R, R, 0, R, R, 1, 2, 1};
    tbl[4]  = '{D, D, 0, R, R, 1, 2, 1};
    tbl[5]  = '{D, D, 0, R, R, 1, 2, 1};
    tbl[6]  = '{D, D, 0, D, D, 1, 2, 1};
    tbl[7]  = '{G, G, 0, D, D, 1, 2, 1};
    tbl[8]  = '{D, D, 0, D, D, 1, 2, 1};
    tbl[9]  = '{D, D, 0, D, D, 1, 2, 1};
    tbl[10] = '{D, D, 0, R, R, 1, 2, 1};
    tbl[11] = '{D, D, 1, R, R, 0, 0, 1};

    ph[0] = '{G, R, 16}; ph[1] = '{Y, R, 4}; ph[2] = '{R, R, 4};
    ph[3] = '{R, G, 16}; ph[4] = '{R, Y, 4}; ph[5] = '{R, R, 4};

    yNS = D; yEW = D; clr_fault = 0; rst = 1;

    // Nominal cycle, twice.
    reset_and_start();
    for (int rep = 0; rep < 2; rep++)
      for (int p = 0; p < 6; p++)
        for (int k = 0; k < ph[p].len; k++) begin
          tick(ph[p].yn, ph[p].ye, 0, 0);
          chk("nominal lampNS", int'(lampNS), int'(ph[p].yn));
          chk("nominal lampEW", int'(lampEW), int'(ph[p].ye));
          chk("nominal fault", int'(fault), 0);
        end

    // Table-driven conflict / flash / clear.
    reset_and_start();
    for (int v = 0; v < 12; v++) begin
      tick(tbl[v].yn, tbl[v].ye, tbl[v].clr, 0);
      chk("tbl lampNS", int'(lampNS), int'(tbl[v].lns));
      chk("tbl lampEW", int'(lampEW), int'(tbl[v].lew));
      chk("tbl fault", int'(fault), int'(tbl[v].flt));
      chk("tbl fault_code", int'(fault_code), tbl[v].code);
      chk("tbl fault_cnt", int'(fault_cnt), tbl[v].cnt);
    end
    // After clear: all red for the startup period, then pass-through.
    for (int k = 0; k < STARTUP_CYC; k++) begin
      tick(G, R, 0, 0);
      chk("clr startup lampNS", int'(lampNS), int'(R));
    end
    tick(G, R, 0, 0);
    chk("resume lampNS", int'(lampNS), int'(G));
    tick(G, R, 1, 0);
    chk("clr in monitor fault", int'(fault), 0);
    chk("clr in monitor lampNS", int'(lampNS), int'(G));
    tick(G, G, 0, 0);
    chk("second fault cnt", int'(fault_cnt), 2);
    chk("second fault code", int'(fault_code), 2);
    // Reset while flashing.
    for (int k = 0; k < 5; k++) tick(R, R, 0, 0);
    chk("flashing dark", int'(lampNS), int'(D));
    tick(G, G, 0, 1);
    chk("rst mid-fault lampNS", int'(lampNS), int'(R));
    chk("rst mid-fault fault", int'(fault), 0);
    chk("rst mid-fault cnt", int'(fault_cnt), 0);
    for (int k = 0; k < STARTUP_CYC; k++) begin
      tick(D, D, 0, 0);
      chk("rst startup no fault", int'(fault), 0);
    end
    tick(G, R, 0, 0);
    chk("rst resume lampNS", int'(lampNS), int'(G));

    // Sequence: NS green straight to red.
    reset_and_start();
    for (int k = 0; k < 10; k++) tick(G, R, 0, 0);
    tick(R, R, 0, 0);
    chk("seq fault", int'(fault), 1);
    chk("seq code", int'(fault_code), 3);
    chk("seq dir", int'(fault_dir), 0);

    // Min-time: EW green only 5 cycles.
    reset_and_start();
    for (int k = 0; k < 4; k++) tick(R, R, 0, 0);
    for (int k = 0; k < 5; k++) tick(R, G, 0, 0);
    tick(R, Y, 0, 0);
    chk("min code", int'(fault_code), 4);
    chk("min dir", int'(fault_dir), 1);
    chk("min lampEW", int'(lampEW), int'(R));

    // Encoding.
    reset_and_start();
    tick(G, R, 0, 0);
    tick(G, R, 0, 0);
    tick(3'b011, R, 0, 0);
    chk("enc code", int'(fault_code), 1);
    chk("enc dir", int'(fault_dir), 0);
    chk("enc lampNS", int'(lampNS), int'(R));

    // Stuck: both directions stuck together, NS reported.
    reset_and_start();
    for (int k = 0; k < MAX_HOLD - 1; k++) tick(G, R, 0, 0);
    chk("stuck not yet", int'(fault), 0);
    tick(G, R, 0, 0);
    chk("stuck fault", int'(fault), 1);
    chk("stuck code", int'(fault_code), 5);
    chk("stuck dir", int'(fault_dir), 0);

    // Randomized traffic with occasional bad codes, clears and resets.
    reset_and_start();
    rn = G; re = R;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        case ($urandom_range(0, 2)) 0: rn = R; 1: rn = Y; default: rn = G; endcase
      end else if (r < 6) begin
        case ($urandom_range(0, 2)) 0: re = R; 1: re = Y; default: re = G; endcase
      end else if (r == 6) begin
        rn = 3'($urandom_range(0, 7));
      end
      tick(rn, re, ($urandom_range(0, 15) == 0), ($urandom_range(0, 699) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
